// File: rtl/chess_pkg.sv
// chess_pkg: move word geometry, flag bit positions and collector FSM states.
package chess_pkg;
    localparam int MOVE_W = 19;
    localparam int SLOTS = 8;
    localparam int WORD_W = MOVE_W * SLOTS;
    localparam int FLG_INVALID = 18;
    localparam int FLG_PROMOTE = 17;
    localparam int FLG_PAWN = 16;
    localparam int FLG_PAWN2 = 15;
    localparam int FLG_EP = 14;
    localparam int FLG_CASTLE = 13;
    localparam int FLG_CAPTURE = 12;
    localparam int FROM_HI = 11;
    localparam int FROM_LO = 6;
    localparam int TO_HI = 5;
    localparam int TO_LO = 0;

    typedef enum logic [1:0] {IDLE, READ, CAPT, SCAN} state_t;

    function automatic logic [SLOTS-1:0] valid_mask(input logic [WORD_W-1:0] w);
        logic [SLOTS-1:0] m;
        for (int k = 0; k < SLOTS; k++) m[k] = ~w[k*MOVE_W+FLG_INVALID];
        return m;
    endfunction
endpackage

// File: rtl/move_collector_if.sv
// move_collector_if: FIFO read port and valid/ready move stream of the collector.
interface move_collector_if;
    import chess_pkg::*;
    logic [WORD_W-1:0] fifo_data;
    logic fifo_empty;
    logic fifo_rden;
    logic [MOVE_W-1:0] mv_data;
    logic mv_valid;
    logic mv_ready;

    modport master (input fifo_data, fifo_empty, mv_ready, output fifo_rden, mv_data, mv_valid);
    modport slave (output fifo_data, fifo_empty, mv_ready, input fifo_rden, mv_data, mv_valid);
endinterface

// File: rtl/mvc_prienc.sv
// mvc_prienc: picks the highest-index set bit of the pending slot mask.
module mvc_prienc
    import chess_pkg::*;
(
    input  logic [SLOTS-1:0] mask_i,
    output logic [2:0]       idx_o,
    output logic             any_o
);
    always_comb begin
        idx_o = '0;
        for (int i = 0; i < SLOTS; i++) idx_o = mask_i[i] ? 3'(i) : idx_o;
    end

    assign any_o = |mask_i;
endmodule

// File: rtl/move_collector.sv
// move_collector: unpacks 8-slot move words into a valid/ready move stream; MOVE_COLLECTOR_COUNT_EN enables move_count.
module move_collector
    import chess_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    move_collector_if.master   bus,
    output logic               busy,
    output logic [9:0]         move_count
);
    state_t state_q, state_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [SLOTS-1:0] mask_q, mask_d;
    logic [MOVE_W-1:0] mv_data_q, mv_data_d;
    logic mv_valid_q, mv_valid_d;
    logic [2:0] idx;
    logic any, free, load, xfer;

    mvc_prienc u_prienc (.mask_i(mask_q), .idx_o(idx), .any_o(any));

    assign free = !mv_valid_q || bus.mv_ready;
    assign xfer = mv_valid_q && bus.mv_ready;

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: state_d = bus.fifo_empty ? IDLE : READ;
            READ: state_d = CAPT;
            CAPT: state_d = SCAN;
            SCAN: state_d = any ? SCAN : (bus.fifo_empty ? IDLE : READ);
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load = state_q == SCAN && any && free;
        bus.fifo_rden = state_q == READ;
        busy = state_q != IDLE || mv_valid_q;
    end

    // A load overrides the clear from a same-cycle transfer, giving one move per cycle.
    always_comb begin
        word_d = state_q == CAPT ? bus.fifo_data : word_q;
        mask_d = state_q == CAPT ? valid_mask(bus.fifo_data) : (load ? mask_q & ~(SLOTS'(1) << idx) : mask_q);
        mv_data_d = load ? word_q[idx*MOVE_W +: MOVE_W] : mv_data_q;
        mv_valid_d = load || (mv_valid_q && !bus.mv_ready);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_q <= '0;
            mask_q <= '0;
            mv_data_q <= '0;
            mv_valid_q <= 1'b0;
        end else begin
            word_q <= word_d;
            mask_q <= mask_d;
            mv_data_q <= mv_data_d;
            mv_valid_q <= mv_valid_d;
        end
    end

    assign bus.mv_data = mv_data_q;
    assign bus.mv_valid = mv_valid_q;

`ifdef MOVE_COLLECTOR_COUNT_EN
    logic [9:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else if (xfer) cnt_q <= cnt_q + 10'd1;
    end

    assign move_count = cnt_q;
`else
    assign move_count = '0;
`endif
endmodule

// File: tb/tb_move_collector.sv
// tb_move_collector: FIFO model plus in-order move scoreboard for move_collector.
module tb_move_collector;
    import chess_pkg::*;

`ifdef MOVE_COLLECTOR_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct {
        logic [7:0] mask;
        int n;
        int lat;
        int span;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic busy;
    logic [9:0] move_count;
    move_collector_if bus();

    move_collector dut (.clk(clk), .reset(reset), .bus(bus), .busy(busy), .move_count(move_count));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    logic [WORD_W-1:0] fifo_q[$];
    logic [MOVE_W-1:0] exp_q[$];
    int rden_cyc[$];
    logic [WORD_W-1:0] pend;
    logic have_pend = 1'b0;
    logic rden_prev = 1'b0;
    logic hold_prev = 1'b0;
    logic [MOVE_W-1:0] held;
    int exp_cnt = 0;
    int n_xfer, n_rden, n_hold, first_xfer, last_xfer, first_valid, fall_cyc;
    vec_t vecs[6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at cycle %0d", nm, act, want, cyc);
        end
    endtask

    function automatic logic [WORD_W-1:0] mk_word(input logic [7:0] m);
        logic [WORD_W-1:0] w;
        for (int k = 0; k < SLOTS; k++) w[k*MOVE_W +: MOVE_W] = {~m[k], 18'($urandom)};
        return w;
    endfunction

    task automatic clear_stats();
        n_xfer = 0; n_rden = 0; n_hold = 0;
        first_xfer = -1; last_xfer = -1; first_valid = -1; fall_cyc = -1;
        rden_cyc.delete();
    endtask

    task automatic drain(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (fifo_q.size() == 0 && !have_pend && exp_q.size() == 0 && !busy && bus.fifo_empty) break;
        end
        chk("drain_timeout", 64'(i >= budget), 0);
        chk("drain_leftover", 64'(exp_q.size()), 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
    endtask

    // FIFO model and scoreboard: samples at the falling edge, presents read data for the CAPT cycle.
    initial begin
        bus.fifo_data = '1;
        bus.fifo_empty = 1'b1;
        bus.mv_ready = 1'b1;
        clear_stats();
        forever begin
            @(negedge clk);
            bus.fifo_data = have_pend ? pend : '1;
            have_pend = 1'b0;
            if (reset) begin
                exp_q.delete();
                exp_cnt = 0;
                hold_prev = 1'b0;
            end else begin
                chk("move_count", 64'(move_count), CNT_EN ? 64'(exp_cnt) : 64'(0));
                if (hold_prev) begin
                    n_hold++;
                    chk("hold_valid", 64'(bus.mv_valid), 1);
                    chk("hold_data", 64'(bus.mv_data), 64'(held));
                end
                if (bus.fifo_rden) begin
                    n_rden++;
                    rden_cyc.push_back(cyc);
                    chk("rden_single", 64'(rden_prev), 0);
                    chk("rden_nonempty", 64'(fifo_q.size() != 0), 1);
                    if (fifo_q.size() != 0) begin
                        pend = fifo_q.pop_front();
                        have_pend = 1'b1;
                        for (int k = SLOTS - 1; k >= 0; k--)
                            if (!pend[k*MOVE_W+FLG_INVALID]) exp_q.push_back(pend[k*MOVE_W +: MOVE_W]);
                    end
                end
                if (bus.mv_valid && first_valid < 0) first_valid = cyc;
                if (bus.mv_valid && bus.mv_ready) begin
                    chk("xfer_expected", 64'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) chk("xfer_data", 64'(bus.mv_data), 64'(exp_q.pop_front()));
                    n_xfer++;
                    if (first_xfer < 0) first_xfer = cyc;
                    last_xfer = cyc;
                    exp_cnt = (exp_cnt + 1) % 1024;
                end
                hold_prev = bus.mv_valid && !bus.mv_ready;
                held = bus.mv_data;
            end
            rden_prev = bus.fifo_rden && !reset;
            if (bus.fifo_empty && fifo_q.size() != 0 && fall_cyc < 0) fall_cyc = cyc;
            bus.fifo_empty = fifo_q.size() == 0;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{mask: 8'h84, n: 2, lat: 4, span: 1};
        vecs[1] = '{mask: 8'h00, n: 0, lat: -1, span: 0};
        vecs[2] = '{mask: 8'hFF, n: 8, lat: 4, span: 7};
        vecs[3] = '{mask: 8'h01, n: 1, lat: 4, span: 0};
        vecs[4] = '{mask: 8'h80, n: 1, lat: 4, span: 0};
        vecs[5] = '{mask: 8'h5A, n: 4, lat: 4, span: 3};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(bus.mv_valid), 0);
        chk("rst_rden", 64'(bus.fifo_rden), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_data", 64'(bus.mv_data), 0);
        chk("rst_count", 64'(move_count), 0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 6; i++) begin
            #1 clear_stats();
            fifo_q.push_back(mk_word(vecs[i].mask));
            drain(200);
            chk($sformatf("vec%0d_xfers", i), 64'(n_xfer), 64'(vecs[i].n));
            chk($sformatf("vec%0d_rden", i), 64'(n_rden), 1);
            chk($sformatf("vec%0d_lat", i), first_valid < 0 ? -64'sd1 : 64'(first_valid - fall_cyc), 64'(vecs[i].lat));
            chk($sformatf("vec%0d_span", i), 64'(last_xfer - first_xfer), 64'(vecs[i].span));
        end

        clear_stats();
        bus.mv_ready = 1'b0;
        fifo_q.push_back(mk_word(8'hFF));
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (bus.mv_valid) break;
        end
        chk("bp_valid_seen", 64'(bus.mv_valid), 1);
        repeat (5) @(posedge clk);
        #1 bus.mv_ready = 1'b1;
        drain(200);
        chk("bp_holds", 64'(n_hold), 5);
        chk("bp_xfers", 64'(n_xfer), 8);

        clear_stats();
        fifo_q.push_back(mk_word(8'h00));
        fifo_q.push_back(mk_word(8'hFF));
        drain(200);
        chk("inv_rden_count", 64'(n_rden), 2);
        chk("inv_rden_gap", 64'(rden_cyc[1] - rden_cyc[0]), 3);
        chk("inv_first_valid", 64'(first_valid - rden_cyc[1]), 3);
        chk("inv_xfers", 64'(n_xfer), 8);

        do_reset();
        clear_stats();
        repeat (3) fifo_q.push_back(mk_word(8'hFF));
        drain(300);
        chk("b2b_xfers", 64'(n_xfer), 24);
        chk("b2b_count", 64'(move_count), CNT_EN ? 64'(24) : 64'(0));

        clear_stats();
        fifo_q.push_back(mk_word(8'hFF));
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (n_xfer == 3) break;
        end
        chk("mid_third", 64'(n_xfer), 3);
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("mid_valid", 64'(bus.mv_valid), 0);
        chk("mid_idle", 64'(busy), 0);
        repeat (15) @(posedge clk);
        chk("mid_xfers", 64'(n_xfer), 3);
        chk("mid_rden", 64'(n_rden), 1);

        clear_stats();
        for (int i = 0; i < 700; i++) begin
            @(posedge clk); #1;
            bus.mv_ready = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 7) == 0 && fifo_q.size() < 4) fifo_q.push_back(mk_word(8'($urandom)));
        end
        bus.mv_ready = 1'b1;
        drain(500);

        do_reset();
        clear_stats();
        repeat (128) fifo_q.push_back(mk_word(8'hFF));
        drain(5000);
        chk("wrap_xfers", 64'(n_xfer), 1024);
        chk("wrap_count", 64'(move_count), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
